// File: rtl/spi_cmd_controller.sv
// Command sequencer between the SPI byte receiver and the BNN OCR image buffer / inference core.
// Decodes command bytes, streams the image payload into the buffer, and starts and tracks inference.
module spi_cmd_controller #(
    parameter int          IMG_BYTES      = 113,
    parameter int          ADDR_W         = 7,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  CMD_LOAD       = 8'hA5,
    parameter logic [7:0]  CMD_START      = 8'h5A,
    parameter logic [7:0]  CMD_CLEAR      = 8'hC3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              byte_valid,
    output logic              rx_enable,
    output logic              byte_taken,
    output logic              img_we,
    output logic [ADDR_W-1:0] img_addr,
    output logic [7:0]        img_wdata,
    output logic              infer_start,
    input  logic              infer_done,
    output logic              img_loaded,
    output logic              busy,
    output logic              err_cmd,
    output logic              err_timeout
);

    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CMD,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              armed;
    logic [ADDR_W-1:0] pay_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    logic accept;
    logic start_load;
    logic write_byte;
    logic set_err_cmd;
    logic clr_err;
    logic timeout;

    // armed blocks re-acceptance until the receiver has dropped byte_valid
    assign accept = byte_valid && armed && (state == S_CMD || state == S_LOAD);

    always_comb begin
        state_nx    = state;
        start_load  = 1'b0;
        write_byte  = 1'b0;
        set_err_cmd = 1'b0;
        clr_err     = 1'b0;
        timeout     = 1'b0;
        case (state)
            S_CMD: begin
                if (accept) begin
                    if (rx_data == CMD_LOAD) begin
                        start_load = 1'b1;
                        state_nx   = S_LOAD;
                    end else if (rx_data == CMD_START) begin
                        if (img_loaded) state_nx = S_START;
                        else            set_err_cmd = 1'b1;
                    end else if (rx_data == CMD_CLEAR) begin
                        clr_err = 1'b1;
                    end else begin
                        set_err_cmd = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    write_byte = 1'b1;
                    if (pay_cnt == LAST_ADDR) state_nx = S_CMD;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_CMD;
                end
            end
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                // infer_start was high in START, so done is only sampled from here on
                if (infer_done) state_nx = S_CMD;
            end
            default: state_nx = S_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CMD;
            armed       <= 1'b1;
            pay_cnt     <= '0;
            tmo_cnt     <= '0;
            rx_enable   <= 1'b0;
            byte_taken  <= 1'b0;
            img_we      <= 1'b0;
            img_addr    <= '0;
            img_wdata   <= '0;
            infer_start <= 1'b0;
            img_loaded  <= 1'b0;
            busy        <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nx;

            if (accept)           armed <= 1'b0;
            else if (!byte_valid) armed <= 1'b1;

            byte_taken <= accept;
            img_we     <= write_byte;
            if (write_byte) begin
                img_addr  <= pay_cnt;
                img_wdata <= rx_data;
            end

            if (start_load)      pay_cnt <= '0;
            else if (write_byte) pay_cnt <= pay_cnt + 1'b1;

            // gap timer only runs while waiting for payload bytes
            if (state != S_LOAD || accept) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + 1'b1;

            if (start_load)                             img_loaded <= 1'b0;
            else if (write_byte && pay_cnt == LAST_ADDR) img_loaded <= 1'b1;

            if (clr_err)          err_cmd <= 1'b0;
            else if (set_err_cmd) err_cmd <= 1'b1;

            if (clr_err)      err_timeout <= 1'b0;
            else if (timeout) err_timeout <= 1'b1;

            rx_enable   <= (state_nx == S_CMD) || (state_nx == S_LOAD);
            infer_start <= (state == S_CMD) && (state_nx == S_START);
            busy        <= (state_nx == S_START) || (state_nx == S_WAIT);
        end
    end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: command decode, payload load, inference handshake,
// payload timeout, error clearing and asynchronous reset during a load.
module tb_spi_cmd_controller;

    localparam int IMG_BYTES = 113;
    localparam int ADDR_W    = 7;
    localparam int TMO       = 200;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              byte_valid;
    logic              rx_enable;
    logic              byte_taken;
    logic              img_we;
    logic [ADDR_W-1:0] img_addr;
    logic [7:0]        img_wdata;
    logic              infer_start;
    logic              infer_done;
    logic              img_loaded;
    logic              busy;
    logic              err_cmd;
    logic              err_timeout;

    int checks = 0;
    int errors = 0;

    int taken_cnt = 0;
    int we_cnt    = 0;
    int start_cnt = 0;
    logic [ADDR_W-1:0] wr_addr [0:511];
    logic [7:0]        wr_data [0:511];

    spi_cmd_controller #(
        .IMG_BYTES      (IMG_BYTES),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .byte_valid  (byte_valid),
        .rx_enable   (rx_enable),
        .byte_taken  (byte_taken),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_wdata   (img_wdata),
        .infer_start (infer_start),
        .infer_done  (infer_done),
        .img_loaded  (img_loaded),
        .busy        (busy),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // event log, sampled on the inactive edge
    always @(negedge clk) begin
        if (byte_taken) taken_cnt++;
        if (infer_start) start_cnt++;
        if (img_we) begin
            if (we_cnt < 512) begin
                wr_addr[we_cnt] = img_addr;
                wr_data[we_cnt] = img_wdata;
            end
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // receiver model: byte_valid held for 'hold' cycles, then released for one cycle
    task automatic send(input logic [7:0] b, input int hold);
        rx_data    = b;
        byte_valid = 1'b1;
        repeat (hold) tick();
        byte_valid = 1'b0;
        tick();
    endtask

    // writes since index w0 must carry addr i and data base+i
    task automatic chk_writes(input string tag, input int w0, input int n, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_addr[w0+i] !== ADDR_W'(i) || wr_data[w0+i] !== 8'(base + i)) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int t0;
        int w0;
        int s0;

        rst_n      = 1'b0;
        rx_data    = 8'h00;
        byte_valid = 1'b0;
        infer_done = 1'b0;
        repeat (3) tick();

        chk("reset_flags", 32'({rx_enable, byte_taken, img_we, infer_start,
                                img_loaded, busy, err_cmd, err_timeout}), 32'd0);
        chk("reset_addr", 32'(img_addr), 32'd0);
        chk("reset_wdata", 32'(img_wdata), 32'd0);

        rst_n = 1'b1;
        tick();
        tick();
        chk("rx_enable_cmd", 32'(rx_enable), 32'd1);

        // START without image, byte_valid held 4 cycles
        t0 = taken_cnt;
        s0 = start_cnt;
        send(8'h5A, 4);
        chk("start_noimg_taken", 32'(taken_cnt - t0), 32'd1);
        chk("start_noimg_err", 32'(err_cmd), 32'd1);
        chk("start_noimg_nostart", 32'(start_cnt - s0), 32'd0);
        chk("start_noimg_busy", 32'(busy), 32'd0);

        send(8'hC3, 3);
        chk("clear_err_cmd", 32'(err_cmd), 32'd0);

        // full load; first payload byte checked cycle by cycle
        t0 = taken_cnt;
        w0 = we_cnt;
        send(8'hA5, 3);
        rx_data    = 8'h00;
        byte_valid = 1'b1;
        tick();
        chk("lat_we", 32'({img_we, byte_taken}), 32'h3);
        chk("lat_addr", 32'(img_addr), 32'd0);
        tick();
        chk("lat_pulse_end", 32'({img_we, byte_taken}), 32'h0);
        tick();
        byte_valid = 1'b0;
        tick();
        chk("load_not_done", 32'(img_loaded), 32'd0);
        for (int i = 1; i < IMG_BYTES; i++) send(8'(i), 3);
        chk("load_we_count", 32'(we_cnt - w0), 32'd113);
        chk("load_taken_count", 32'(taken_cnt - t0), 32'd114);
        chk_writes("load_contents", w0, IMG_BYTES, 0);
        chk("load_loaded", 32'(img_loaded), 32'd1);
        chk("load_addr_hold", 32'(img_addr), 32'd112);
        chk("load_we_idle", 32'(img_we), 32'd0);

        // inference
        s0 = start_cnt;
        send(8'h5A, 3);
        chk("infer_start_once", 32'(start_cnt - s0), 32'd1);
        chk("infer_busy", 32'(busy), 32'd1);
        chk("infer_rx_off", 32'(rx_enable), 32'd0);
        t0 = taken_cnt;
        send(8'h42, 4);
        chk("busy_no_take", 32'(taken_cnt - t0), 32'd0);
        chk("busy_no_err", 32'(err_cmd), 32'd0);
        infer_done = 1'b1;
        tick();
        infer_done = 1'b0;
        tick();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_rx_on", 32'(rx_enable), 32'd1);
        chk("done_loaded", 32'(img_loaded), 32'd1);

        // payload timeout after 10 bytes
        w0 = we_cnt;
        send(8'hA5, 3);
        chk("reload_clears_loaded", 32'(img_loaded), 32'd0);
        for (int i = 0; i < 10; i++) send(8'(8'h80 + i), 3);
        chk("tmo_we_count", 32'(we_cnt - w0), 32'd10);
        chk_writes("tmo_contents", w0, 10, 8'h80);
        repeat (100) tick();
        chk("tmo_not_early", 32'(err_timeout), 32'd0);
        repeat (110) tick();
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        chk("tmo_loaded", 32'(img_loaded), 32'd0);
        w0 = we_cnt;
        send(8'hC3, 3);
        chk("tmo_clear_is_cmd", 32'(we_cnt - w0), 32'd0);
        chk("tmo_cleared", 32'({err_cmd, err_timeout}), 32'd0);

        // unknown command, then a full load still works
        send(8'h00, 3);
        chk("unknown_cmd_err", 32'(err_cmd), 32'd1);
        w0 = we_cnt;
        send(8'hA5, 3);
        for (int i = 0; i < IMG_BYTES; i++) send(8'(i), 3);
        chk("load2_we_count", 32'(we_cnt - w0), 32'd113);
        chk_writes("load2_contents", w0, IMG_BYTES, 0);
        chk("load2_loaded", 32'(img_loaded), 32'd1);
        chk("load2_err_sticky", 32'(err_cmd), 32'd1);

        // asynchronous reset while byte 50 is being written
        send(8'hC3, 3);
        send(8'hA5, 3);
        for (int i = 0; i < 50; i++) send(8'(i), 3);
        rx_data    = 8'd50;
        byte_valid = 1'b1;
        tick();
        chk("pre_rst_we", 32'(img_we), 32'd1);
        chk("pre_rst_addr", 32'(img_addr), 32'd50);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", 32'({rx_enable, byte_taken, img_we, infer_start,
                                    img_loaded, busy, err_cmd, err_timeout}), 32'd0);
        chk("async_rst_addr", 32'(img_addr), 32'd0);
        chk("async_rst_wdata", 32'(img_wdata), 32'd0);
        byte_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        w0 = we_cnt;
        send(8'hA5, 3);
        for (int i = 0; i < 3; i++) send(8'(8'hE0 + i), 3);
        chk("restart_we_count", 32'(we_cnt - w0), 32'd3);
        chk_writes("restart_contents", w0, 3, 8'hE0);
        chk("restart_loaded", 32'(img_loaded), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Sequences the SPI byte receiver for the BNN OCR core.
- Gates the receiver with rx_enable and consumes bytes through the byte_valid/byte_taken handshake.
- Decodes command bytes, streams image bytes into the image buffer write port, then starts inference and waits for it to finish.
- Sits between the SPI byte receiver and the image buffer / inference core.

Parameters:
IMG_BYTES, 113, image payload length in bytes (30x30 bits, packed MSB-first, last byte zero-padded)
ADDR_W, 7, image buffer address width; must satisfy 2**ADDR_W >= IMG_BYTES
TIMEOUT_CYCLES, 100000, max clk cycles between payload bytes before abort
CMD_LOAD, 8'hA5, command: load image payload
CMD_START, 8'h5A, command: start inference
CMD_CLEAR, 8'hC3, command: clear status flags

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from SPI receiver
byte_valid  in  1  received byte available
rx_enable  out  1  enables SPI reception
byte_taken  out  1  one-cycle pulse: byte consumed
img_we  out  1  image buffer write strobe
img_addr  out  ADDR_W  image buffer write address
img_wdata  out  8  image buffer write data
infer_start  out  1  one-cycle inference start pulse
infer_done  in  1  inference core finished (pulse or level)
img_loaded  out  1  full image present in buffer
busy  out  1  inference in progress
err_cmd  out  1  sticky: unknown command, or START with no image
err_timeout  out  1  sticky: payload byte gap exceeded TIMEOUT_CYCLES

Behaviour:
- Reset values (async, all outputs 0): rx_enable, byte_taken, img_we, img_addr, img_wdata, infer_start, img_loaded, busy, err_cmd, err_timeout. State = CMD. armed = 1.
- Byte acceptance:
  - A byte is accepted only when byte_valid=1, armed=1 and the state accepts bytes.
  - On acceptance: byte_taken=1 for exactly one cycle, then armed clears.
  - armed sets again on the first cycle byte_valid is sampled 0. This absorbs the receiver's 2-cycle byte_valid release latency, so no byte is taken twice.
- States:
  - CMD: rx_enable=1.
    - CMD_LOAD -> LOAD, payload counter=0, img_loaded cleared.
    - CMD_START with img_loaded=1 -> START. With img_loaded=0 -> err_cmd=1, stay in CMD.
    - CMD_CLEAR -> err_cmd=0, err_timeout=0, stay in CMD.
    - Any other byte -> err_cmd=1, stay in CMD.
  - LOAD: rx_enable=1.
    - Each accepted byte, same cycle as byte_taken: img_we=1, img_addr=counter, img_wdata=rx_data; counter increments. Write latency is 1 cycle from the byte_valid sample.
    - The write with counter==IMG_BYTES-1 -> img_loaded=1, return to CMD.
    - Timeout counter resets on entry and on each accepted byte. Reaching TIMEOUT_CYCLES -> err_timeout=1, img_loaded stays 0, return to CMD, buffer contents undefined.
  - START: rx_enable=0, infer_start=1 for one cycle, busy=1 -> WAIT.
  - WAIT: rx_enable=0, busy=1. No bytes accepted; byte_taken stays 0.
    - infer_done=1 -> busy=0, img_loaded stays 1 (re-run allowed), go to CMD.
    - infer_done asserted in the same cycle as START is ignored; sampling starts the cycle after infer_start.
- img_addr holds its last value when img_we=0. img_we is never asserted outside LOAD.
- Error flags are sticky. Only CMD_CLEAR or reset clears them. A CMD_CLEAR byte is consumed normally.
- Reset mid-LOAD or mid-WAIT: immediate return to CMD with all outputs at reset values. The inference core is reset separately.

Test Plan:
- Bytes A5 followed by 113 bytes 0x00..0x70 -> 113 img_we pulses, addr 0..112, wdata==addr; img_loaded=1 after the last write; exactly 113+1 byte_taken pulses.
- byte_valid held high 4 cycles for one byte 0x5A with img_loaded=0 -> a single byte_taken, err_cmd=1, no infer_start.
- After a full load, byte 5A -> one infer_start pulse, busy=1. Byte 0x42 sent during busy -> not taken. infer_done pulse -> busy=0, back to CMD.
- A5 then 10 payload bytes then idle for TIMEOUT_CYCLES (bench uses 200) -> err_timeout=1, img_loaded=0. Then C3 -> both errors cleared.
- Byte 0x00 in CMD -> err_cmd=1. Then A5 plus a full payload still loads correctly.
- rst_n low at payload byte 50 -> all outputs 0 asynchronously. After release, A5 restarts the load at addr 0.
